// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the mult cell sequencer.
package mult_seq_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    MUL_LO,
    SUM_LO,
    MUL_HI,
    SUM_HI,
    RESP
  } state_e;

  // Width of the wait counter that spans 0 .. lat-1.
  function automatic int unsigned wait_cnt_w(input int unsigned lat);
    return (lat <= 1) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/mult_cell_seq_if.sv
// Request/response channels between the execute stage and the multiply sequencer.
interface mult_cell_seq_if;

  logic                             req_valid;
  logic                             req_ready;
  logic [mult_seq_pkg::XLEN-1:0]    req_a;
  logic [mult_seq_pkg::XLEN-1:0]    req_b;
  logic                             req_hi;
  logic                             rsp_valid;
  logic                             rsp_ready;
  logic [mult_seq_pkg::XLEN-1:0]    rsp_data;

  modport master (
    output req_valid, req_a, req_b, req_hi, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, req_hi, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/mult_seq_fold.sv
// Folds the three 16x16 partial products into the low product word and the
// pending high-word accumulator.
module mult_seq_fold
  import mult_seq_pkg::*;
(
  input  logic [XLEN-1:0] p1_i,   // a_lo*b_lo
  input  logic [XLEN-1:0] p2_i,   // a_lo*b_hi
  input  logic [XLEN-1:0] p3_i,   // a_hi*b_lo
  output logic [XLEN-1:0] lo_o,
  output logic [XLEN-1:0] hacc_o
);

  localparam int unsigned TW = HALF_W + 2;

  logic [TW-1:0] t;

  always_comb begin
    t      = TW'(p1_i[XLEN-1:HALF_W]) + TW'(p2_i[HALF_W-1:0]) + TW'(p3_i[HALF_W-1:0]);
    lo_o   = {t[HALF_W-1:0], p1_i[HALF_W-1:0]};
    hacc_o = XLEN'(p2_i[XLEN-1:HALF_W]) + XLEN'(p3_i[XLEN-1:HALF_W])
           + XLEN'(t[TW-1:HALF_W]);
  end

endmodule

// File: rtl/mult_cell_seq.sv
// Sequencer for the three-partial-product 16x16 mult cell; returns the 32x32
// product low word, or the high word when MULT_SEQ_MULX_EN is defined.
module mult_cell_seq
  import mult_seq_pkg::*;
#(
  parameter int unsigned CELL_LATENCY = 1,
  parameter int unsigned DATA_W       = 32
) (
  input  logic            clk,
  input  logic            reset,
  mult_cell_seq_if.slave  bus,
  output logic            busy,
  output logic [XLEN-1:0] cell_src1,
  output logic [XLEN-1:0] cell_src2,
  output logic            cell_en,
  input  logic [XLEN-1:0] cell_p1,
  input  logic [XLEN-1:0] cell_p2,
  input  logic [XLEN-1:0] cell_p3
);

  if (DATA_W != XLEN) begin : g_bad_width
    $error("mult_cell_seq: DATA_W must be 32");
  end
  if (CELL_LATENCY < 1 || CELL_LATENCY > 4) begin : g_bad_latency
    $error("mult_cell_seq: CELL_LATENCY must be 1..4");
  end

  localparam int unsigned WCW = wait_cnt_w(CELL_LATENCY);

  state_e            state_q, state_d;
  logic [WCW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]   src1_q, src1_d;
  logic [XLEN-1:0]   src2_q, src2_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [XLEN-1:0]   lo_w, hacc_w;
  logic              last_cnt;

`ifdef MULT_SEQ_MULX_EN
  logic              hi_q, hi_d;
  logic [XLEN-1:0]   hacc_q, hacc_d;
`else
  logic              unused_mulx;
  assign unused_mulx = ^{bus.req_hi, hacc_w};
`endif

  mult_seq_fold u_fold (
    .p1_i   (cell_p1),
    .p2_i   (cell_p2),
    .p3_i   (cell_p3),
    .lo_o   (lo_w),
    .hacc_o (hacc_w)
  );

  assign last_cnt     = (cnt_q == WCW'(CELL_LATENCY - 1));
  // Source registers double as operand storage and keep the cell inputs
  // steady between passes so its partials stay put.
  assign cell_src1    = src1_q;
  assign cell_src2    = src2_q;
  assign bus.rsp_data = data_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    src1_d        = src1_q;
    src2_d        = src2_q;
    data_d        = data_q;
`ifdef MULT_SEQ_MULX_EN
    hi_d          = hi_q;
    hacc_d        = hacc_q;
`endif
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    cell_en       = 1'b0;
    busy          = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          src1_d  = bus.req_a;
          src2_d  = bus.req_b;
`ifdef MULT_SEQ_MULX_EN
          hi_d    = bus.req_hi;
`endif
          cnt_d   = '0;
          state_d = MUL_LO;
        end
      end

      MUL_LO: begin
        cell_en = 1'b1;
        if (last_cnt) begin
          cnt_d   = '0;
          state_d = SUM_LO;
        end else begin
          cnt_d   = cnt_q + WCW'(1);
        end
      end

      SUM_LO: begin
        data_d  = lo_w;
        state_d = RESP;
`ifdef MULT_SEQ_MULX_EN
        hacc_d  = hacc_w;
        if (hi_q) begin
          src1_d  = XLEN'(src1_q[XLEN-1:HALF_W]);
          src2_d  = XLEN'(src2_q[XLEN-1:HALF_W]);
          state_d = MUL_HI;
        end
`endif
      end

`ifdef MULT_SEQ_MULX_EN
      MUL_HI: begin
        cell_en = 1'b1;
        if (last_cnt) begin
          cnt_d   = '0;
          state_d = SUM_HI;
        end else begin
          cnt_d   = cnt_q + WCW'(1);
        end
      end

      SUM_HI: begin
        data_d  = cell_p1 + hacc_q;
        state_d = RESP;
      end
`endif

      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      data_q  <= '0;
`ifdef MULT_SEQ_MULX_EN
      hi_q    <= 1'b0;
      hacc_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      data_q  <= data_d;
`ifdef MULT_SEQ_MULX_EN
      hi_q    <= hi_d;
      hacc_q  <= hacc_d;
`endif
    end
  end

endmodule

// File: tb/tb_mult_cell_seq.sv
// Directed bench for mult_cell_seq: two instances (cell latency 1 and 3), each
// fed by a behavioural model of the 16x16 partial-product cell.
`timescale 1ns/1ps
module tb_mult_cell_seq;

  localparam int unsigned L0 = 1;
  localparam int unsigned L1 = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  mult_cell_seq_if if0();
  mult_cell_seq_if if1();

  logic        busy0, busy1, en0, en1;
  logic [31:0] s1_0, s2_0, s1_1, s2_1;
  logic [31:0] p1_0, p2_0, p3_0, p1_1, p2_1, p3_1;

  mult_cell_seq #(.CELL_LATENCY(L0), .DATA_W(32)) dut0 (
    .clk(clk), .reset(reset), .bus(if0), .busy(busy0),
    .cell_src1(s1_0), .cell_src2(s2_0), .cell_en(en0),
    .cell_p1(p1_0), .cell_p2(p2_0), .cell_p3(p3_0)
  );

  mult_cell_seq #(.CELL_LATENCY(L1), .DATA_W(32)) dut1 (
    .clk(clk), .reset(reset), .bus(if1), .busy(busy1),
    .cell_src1(s1_1), .cell_src2(s2_1), .cell_en(en1),
    .cell_p1(p1_1), .cell_p2(p2_1), .cell_p3(p3_1)
  );

  // Cell model: {a_lo*b_lo, a_lo*b_hi, a_hi*b_lo}, captured on enable,
  // delayed through a latency-deep pipe that holds when enable drops.
  function automatic logic [95:0] cell_pp(input logic [31:0] s1, input logic [31:0] s2);
    logic [31:0] al, ah, bl, bh;
    al = {16'h0, s1[15:0]};
    ah = {16'h0, s1[31:16]};
    bl = {16'h0, s2[15:0]};
    bh = {16'h0, s2[31:16]};
    return {al * bl, al * bh, ah * bl};
  endfunction

  logic [95:0] pipe0 [L0] = '{default: '0};
  logic [95:0] pipe1 [L1] = '{default: '0};

  always @(posedge clk) begin
    if (en0) pipe0[0] <= cell_pp(s1_0, s2_0);
  end

  always @(posedge clk) begin
    if (en1) pipe1[0] <= cell_pp(s1_1, s2_1);
    for (int i = 1; i < int'(L1); i++) pipe1[i] <= pipe1[i-1];
  end

  assign {p1_0, p2_0, p3_0} = pipe0[L0-1];
  assign {p1_1, p2_1, p3_1} = pipe1[L1-1];

  // Drives one transaction on dut0 (must be idle), returns data, latency and
  // cell_en cycle count. Latency 50 means rsp_valid never came.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic hi,
                       output logic [31:0] data, output int lat, output int ens);
    if0.req_a = a; if0.req_b = b; if0.req_hi = hi; if0.req_valid = 1'b1;
    @(posedge clk); #1;
    if0.req_valid = 1'b0;
    lat = 1; ens = 0;
    while (!if0.rsp_valid && lat < 50) begin
      if (en0) ens++;
      @(posedge clk); #1;
      lat++;
    end
    data = if0.rsp_data;
    if0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    if0.rsp_ready = 1'b0;
  endtask

  logic [31:0] va [5] = '{32'h0000FFFF, 32'h00010003, 32'h0000FFFF, 32'hFFFFFFFF, 32'h00010000};
  logic [31:0] vb [5] = '{32'h0000FFFF, 32'h00020005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000};
  logic [31:0] vlo[5] = '{32'hFFFE0001, 32'h000B000F, 32'hFFFF0001, 32'h00000001, 32'h00000000};
  logic [31:0] vhi[5] = '{32'h00000000, 32'h00000002, 32'h0000FFFE, 32'hFFFFFFFE, 32'h00000001};

`ifdef MULT_SEQ_MULX_EN
  localparam int HI_LAT = 5;
  localparam int HI_ENS = 2;
`else
  localparam int HI_LAT = 3;
  localparam int HI_ENS = 1;
`endif

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (if0.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", if0.req_ready); end
    checks++; if (if0.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", if0.rsp_valid); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    checks++; if (en0 !== 1'b0) begin errors++; $display("FAIL reset_cell_en: got %b expected 0", en0); end
    checks++; if (s1_0 !== 32'h0 || s2_0 !== 32'h0) begin errors++; $display("FAIL reset_cell_src: got %h/%h expected 0/0", s1_0, s2_0); end
    checks++; if (if0.rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", if0.rsp_data); end
    checks++; if (if1.req_ready !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL reset_dut1: got ready=%b busy=%b expected 1/0", if1.req_ready, busy1); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_low_word();
    logic [31:0] d; int lat, ens;
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], 1'b0, d, lat, ens);
      checks++; if (d !== vlo[i]) begin errors++; $display("FAIL low_data[%0d]: got %h expected %h", i, d, vlo[i]); end
      checks++; if (lat != 3) begin errors++; $display("FAIL low_latency[%0d]: got %0d expected 3", i, lat); end
      checks++; if (ens != 1) begin errors++; $display("FAIL low_cell_en[%0d]: got %0d expected 1", i, ens); end
      checks++; if (if0.req_ready !== 1'b1) begin errors++; $display("FAIL low_ready_after[%0d]: got %b expected 1", i, if0.req_ready); end
    end
  endtask

  task automatic test_high_word();
    logic [31:0] d, exp; int lat, ens;
    for (int i = 0; i < 5; i++) begin
`ifdef MULT_SEQ_MULX_EN
      exp = vhi[i];
`else
      exp = vlo[i];
`endif
      do_op(va[i], vb[i], 1'b1, d, lat, ens);
      checks++; if (d !== exp) begin errors++; $display("FAIL high_data[%0d]: got %h expected %h", i, d, exp); end
      checks++; if (lat != HI_LAT) begin errors++; $display("FAIL high_latency[%0d]: got %0d expected %0d", i, lat, HI_LAT); end
      checks++; if (ens != HI_ENS) begin errors++; $display("FAIL high_cell_en[%0d]: got %0d expected %0d", i, ens, HI_ENS); end
    end
  endtask

  task automatic test_cross_word();
    int n;
    if0.req_a = 32'h00010000; if0.req_b = 32'h00010000; if0.req_hi = 1'b1; if0.req_valid = 1'b1;
    @(posedge clk); #1;
    if0.req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
`ifdef MULT_SEQ_MULX_EN
    checks++; if (en0 !== 1'b1 || s1_0 !== 32'h1 || s2_0 !== 32'h1) begin errors++; $display("FAIL cross_second_pass: got en=%b src=%h/%h expected 1 00000001/00000001", en0, s1_0, s2_0); end
`else
    checks++; if (en0 !== 1'b0 || s1_0 !== 32'h00010000 || if0.rsp_valid !== 1'b1) begin errors++; $display("FAIL cross_no_second_pass: got en=%b src1=%h valid=%b expected 0 00010000 1", en0, s1_0, if0.rsp_valid); end
`endif
    n = 0;
    while (!if0.rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
`ifdef MULT_SEQ_MULX_EN
    checks++; if (if0.rsp_data !== 32'h1) begin errors++; $display("FAIL cross_data: got %h expected 00000001", if0.rsp_data); end
`else
    checks++; if (if0.rsp_data !== 32'h0) begin errors++; $display("FAIL cross_data: got %h expected 00000000", if0.rsp_data); end
`endif
    if0.rsp_ready = 1'b1; @(posedge clk); #1; if0.rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    if0.req_a = 32'd3; if0.req_b = 32'd5; if0.req_hi = 1'b0; if0.req_valid = 1'b1;
    @(posedge clk); #1;
    if0.req_a = 32'hDEADBEEF; if0.req_b = 32'h12345678;
    n = 0;
    while (!if0.rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (if0.rsp_valid !== 1'b1 || if0.rsp_data !== 32'hF || if0.req_ready !== 1'b0 || en0 !== 1'b0 || busy0 !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: got valid=%b data=%h ready=%b en=%b busy=%b expected 1 0000000f 0 0 1",
                 c, if0.rsp_valid, if0.rsp_data, if0.req_ready, en0, busy0);
      end
      @(posedge clk); #1;
    end
    if0.req_valid = 1'b0;
    if0.rsp_ready = 1'b1; @(posedge clk); #1; if0.rsp_ready = 1'b0;
    checks++; if (if0.rsp_valid !== 1'b0 || if0.req_ready !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL backpressure_release: got valid=%b ready=%b busy=%b expected 0 1 0", if0.rsp_valid, if0.req_ready, busy0); end
  endtask

  task automatic test_early_ready();
    int n;
    if0.rsp_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (if0.rsp_valid !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL early_ready_idle: got valid=%b busy=%b expected 0 0", if0.rsp_valid, busy0); end
    if0.req_a = 32'h00010003; if0.req_b = 32'h00020005; if0.req_hi = 1'b0; if0.req_valid = 1'b1;
    @(posedge clk); #1;
    if0.req_valid = 1'b0;
    n = 1;
    while (!if0.rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    checks++; if (n != 3 || if0.rsp_data !== 32'h000B000F) begin errors++; $display("FAIL early_ready_resp: got lat=%0d data=%h expected 3 000b000f", n, if0.rsp_data); end
    @(posedge clk); #1;
    checks++; if (if0.rsp_valid !== 1'b0 || if0.req_ready !== 1'b1) begin errors++; $display("FAIL early_ready_done: got valid=%b ready=%b expected 0 1", if0.rsp_valid, if0.req_ready); end
    if0.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] d; int lat, ens, seen;
    if0.req_a = 32'hFFFFFFFF; if0.req_b = 32'hFFFFFFFF; if0.req_hi = 1'b1; if0.req_valid = 1'b1;
    @(posedge clk); #1;
    if0.req_valid = 1'b0;
`ifdef MULT_SEQ_MULX_EN
    repeat (2) begin @(posedge clk); #1; end
`endif
    checks++; if (en0 !== 1'b1) begin errors++; $display("FAIL midop_in_flight: got cell_en=%b expected 1", en0); end
    reset = 1'b1; #1;
    checks++; if (if0.rsp_valid !== 1'b0 || busy0 !== 1'b0 || if0.req_ready !== 1'b1 || en0 !== 1'b0) begin
      errors++; $display("FAIL midop_reset: got valid=%b busy=%b ready=%b en=%b expected 0 0 1 0", if0.rsp_valid, busy0, if0.req_ready, en0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (if0.rsp_valid) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL midop_no_response: got %0d valid cycles expected 0", seen); end
    do_op(32'd3, 32'd5, 1'b0, d, lat, ens);
    checks++; if (d !== 32'hF || lat != 3) begin errors++; $display("FAIL midop_next_op: got data=%h lat=%0d expected 0000000f 3", d, lat); end
  endtask

  task automatic test_latency3();
    int lat, ens;
    logic [31:0] exp;
    int exp_lat, exp_ens;
`ifdef MULT_SEQ_MULX_EN
    exp = 32'hFFFFFFFE; exp_lat = 9; exp_ens = 6;
`else
    exp = 32'h00000001; exp_lat = 5; exp_ens = 3;
`endif
    if1.req_a = 32'hFFFFFFFF; if1.req_b = 32'hFFFFFFFF; if1.req_hi = 1'b1; if1.req_valid = 1'b1;
    @(posedge clk); #1;
    if1.req_valid = 1'b0;
    lat = 1; ens = 0;
    while (!if1.rsp_valid && lat < 50) begin
      if (en1) ens++;
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (if1.rsp_data !== exp) begin errors++; $display("FAIL lat3_data: got %h expected %h", if1.rsp_data, exp); end
    checks++; if (lat != exp_lat) begin errors++; $display("FAIL lat3_latency: got %0d expected %0d", lat, exp_lat); end
    checks++; if (ens != exp_ens) begin errors++; $display("FAIL lat3_cell_en: got %0d expected %0d", ens, exp_ens); end
    if1.rsp_ready = 1'b1; @(posedge clk); #1; if1.rsp_ready = 1'b0;
    checks++; if (if1.req_ready !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL lat3_idle: got ready=%b busy=%b expected 1 0", if1.req_ready, busy1); end
  endtask

  initial begin
    reset = 1'b1;
    if0.req_valid = 1'b0; if0.req_a = '0; if0.req_b = '0; if0.req_hi = 1'b0; if0.rsp_ready = 1'b0;
    if1.req_valid = 1'b0; if1.req_a = '0; if1.req_b = '0; if1.req_hi = 1'b0; if1.rsp_ready = 1'b0;
    test_reset();
    test_low_word();
    test_high_word();
    test_cross_word();
    test_backpressure();
    test_early_ready();
    test_reset_mid_op();
    test_latency3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
